// File: rtl/spi_defs.sv
// Shared definitions for the SPI master: state encoding, default word
// width and serial clock divider, and a small sizing helper.
package spi_defs;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_LOW   = 3'd2,
      ST_HIGH  = 3'd3,
      ST_HOLD  = 3'd4
   } spi_state_t;

   localparam int SPI_WORD_WIDTH = 96;
   localparam int SPI_CLK_DIV    = 4;

   // Largest of three phase lengths; sizes the shared phase timer.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/spi_master.sv
// SPI master, mode 0, MSB first, one WIDTH-bit word per transaction.
// sclk is a registered divided output; everything runs on `clock`.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | n_cs high, waiting for start (also the cycle done pulses)
// ST_SETUP | n_cs low, first bit on mosi, CS_SETUP cycles before sclk
// ST_LOW   | sclk low half-period; miso captured on its last cycle
// ST_HIGH  | sclk high half-period; bit count / tx shift on last cycle
// ST_HOLD  | sclk low, n_cs still low for CS_HOLD cycles
//
// All pins are registered from the current FSM state, so they trail the
// state by one cycle. That lag is the leading "1" of the transaction
// latency and puts the done pulse on the same edge n_cs rises.
module spi_master
   import spi_defs::*;
#(
   parameter int WIDTH    = SPI_WORD_WIDTH,
   parameter int CLK_DIV  = SPI_CLK_DIV,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] data_i,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] data_o,
   output logic             n_cs,
   output logic             sclk,
   output logic             mosi,
   input  logic             miso
);

   localparam int PMAX = max3(CLK_DIV, CS_SETUP, CS_HOLD);
   localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;
   localparam int BW   = $clog2(WIDTH + 1);

   spi_state_t       r_state;
   spi_state_t       w_state_nx;
   logic [PW-1:0]    r_phase;
   logic [BW-1:0]    r_bit_cnt;
   logic [WIDTH-1:0] r_tx;
   logic [WIDTH-1:0] r_rx;
   logic             r_fin;
   logic             w_phase_tc;
   logic             w_last_bit;

   assign w_phase_tc = (r_phase == '0);
   assign w_last_bit = (r_bit_cnt == BW'(WIDTH - 1));

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // Next-state decode; every timed state leaves on phase terminal count.
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         ST_IDLE:  if (start)      w_state_nx = ST_SETUP;
         ST_SETUP: if (w_phase_tc) w_state_nx = ST_LOW;
         ST_LOW:   if (w_phase_tc) w_state_nx = ST_HIGH;
         ST_HIGH:  if (w_phase_tc) w_state_nx = w_last_bit ? ST_HOLD : ST_LOW;
         ST_HOLD:  if (w_phase_tc) w_state_nx = ST_IDLE;
         default:                  w_state_nx = ST_IDLE;
      endcase
   end

   // Phase timer, bit counter and shift registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_phase   <= '0;
         r_bit_cnt <= '0;
         r_tx      <= '0;
         r_rx      <= '0;
         r_fin     <= 1'b0;
      end else begin
         r_fin <= 1'b0;

         // Reload on every state change, otherwise count down to zero.
         if (w_state_nx != r_state) begin
            case (w_state_nx)
               ST_SETUP: r_phase <= PW'(CS_SETUP - 1);
               ST_LOW:   r_phase <= PW'(CLK_DIV - 1);
               ST_HIGH:  r_phase <= PW'(CLK_DIV - 1);
               ST_HOLD:  r_phase <= PW'(CS_HOLD - 1);
               default:  r_phase <= '0;
            endcase
         end else if (!w_phase_tc) begin
            r_phase <= r_phase - PW'(1);
         end

         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_tx      <= data_i;
                  r_rx      <= '0;
                  r_bit_cnt <= '0;
               end
            end
            ST_LOW: begin
               if (w_phase_tc) r_rx <= {r_rx[WIDTH-2:0], miso};
            end
            ST_HIGH: begin
               if (w_phase_tc) begin
                  r_bit_cnt <= r_bit_cnt + BW'(1);
                  if (!w_last_bit) r_tx <= {r_tx[WIDTH-2:0], 1'b0};
               end
            end
            ST_HOLD: begin
               if (w_phase_tc) r_fin <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Registered pins, one cycle behind the state they represent.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         n_cs   <= 1'b1;
         sclk   <= 1'b0;
         mosi   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         data_o <= '0;
      end else begin
         n_cs <= (r_state == ST_IDLE);
         sclk <= (r_state == ST_HIGH);
         mosi <= (r_state != ST_IDLE) ? r_tx[WIDTH-1] : 1'b0;
         busy <= (r_state != ST_IDLE);
         done <= r_fin;
         if (r_fin) data_o <= r_rx;
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a default-parameter instance driven from a vector
// table (loopback or a behavioural slave), hand-written corner sequences,
// and a WIDTH=8 / CLK_DIV=3 instance in loopback.
module tb_spi_master;
   import spi_defs::*;

   localparam int W    = 96;
   localparam int CD   = 4;
   localparam int CSS  = 2;
   localparam int CSH  = 2;
   localparam int LAT  = 1 + CSS + 2 * CD * W + CSH;
   localparam int W2   = 8;
   localparam int LAT2 = 1 + 1 + 2 * 3 * W2 + 1;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] data_i = '0;
   logic [W-1:0] data_o;
   logic         busy, done, n_cs, sclk, mosi, miso;
   logic         loopback = 1'b1;
   logic [W-1:0] slave_word = '0;
   logic         slave_miso = 1'b0;

   logic          start2 = 1'b0;
   logic [W2-1:0] data2_i = '0;
   logic [W2-1:0] data2_o;
   logic          busy2, done2, n_cs2, sclk2, mosi2;

   always #5 clock = ~clock;

   assign miso = loopback ? mosi : slave_miso;

   spi_master #(.WIDTH(W), .CLK_DIV(CD), .CS_SETUP(CSS), .CS_HOLD(CSH)) u_dut (
      .clock(clock), .reset(reset), .start(start), .data_i(data_i),
      .busy(busy), .done(done), .data_o(data_o), .n_cs(n_cs),
      .sclk(sclk), .mosi(mosi), .miso(miso)
   );

   spi_master #(.WIDTH(W2), .CLK_DIV(3), .CS_SETUP(1), .CS_HOLD(1)) u_small (
      .clock(clock), .reset(reset), .start(start2), .data_i(data2_i),
      .busy(busy2), .done(done2), .data_o(data2_o), .n_cs(n_cs2),
      .sclk(sclk2), .mosi(mosi2), .miso(mosi2)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clock) cyc <= cyc + 1;

   // Bus monitor and behavioural slave: counts sclk rises, collects mosi
   // bits on rises, drives the slave word MSB first (next bit after each
   // sclk fall), counts done pulses and measures n_cs high runs.
   int           rises = 0, rises2 = 0, done_cnt = 0, done2_cnt = 0;
   int           hi_run = 0, last_hi_run = 0, s_idx = 0;
   logic [W-1:0] mosi_word = '0;
   logic [W2-1:0] mosi2_word = '0;
   logic         p_sclk = 1'b0, p_ncs = 1'b1, p_sclk2 = 1'b0;

   always @(negedge clock) begin
      if (sclk && !p_sclk) begin
         rises = rises + 1;
         mosi_word = {mosi_word[W-2:0], mosi};
      end
      if (!n_cs && p_ncs) begin
         last_hi_run = hi_run;
         hi_run = 0;
         s_idx = W - 1;
         slave_miso = slave_word[W-1];
      end else if (n_cs) begin
         hi_run = hi_run + 1;
      end
      if (!sclk && p_sclk && !n_cs && s_idx > 0) begin
         s_idx = s_idx - 1;
         slave_miso = slave_word[s_idx];
      end
      if (done) done_cnt = done_cnt + 1;
      if (sclk2 && !p_sclk2) begin
         rises2 = rises2 + 1;
         mosi2_word = {mosi2_word[W2-2:0], mosi2};
      end
      if (done2) done2_cnt = done2_cnt + 1;
      p_sclk  = sclk;
      p_ncs   = n_cs;
      p_sclk2 = sclk2;
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clock);
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_done2(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clock);
         if (done2) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // One full transaction on the default instance.
   task automatic run_txn(input logic [W-1:0] d, input logic [W-1:0] sw, input bit lb,
                          input logic [W-1:0] exp_o, input string tag);
      int r0, d0, t0;
      bit ok;
      @(negedge clock);
      data_i = d; slave_word = sw; loopback = lb;
      r0 = rises; d0 = done_cnt;
      start = 1'b1;
      @(negedge clock);
      t0 = cyc;
      start = 1'b0;
      data_i = ~d;
      @(negedge clock);
      check({tag, ".busy"}, W'(busy), W'(1));
      wait_done(LAT + 50, ok);
      check_int({tag, ".done_seen"}, int'(ok), 1);
      check_int({tag, ".latency"}, cyc - t0, LAT);
      check({tag, ".data_o"}, data_o, exp_o);
      check({tag, ".mosi_word"}, mosi_word, d);
      check_int({tag, ".rises"}, rises - r0, W);
      @(negedge clock);
      check({tag, ".done_width"}, W'(done), W'(0));
      check({tag, ".idle"}, W'({busy, n_cs}), W'(2'b01));
      check_int({tag, ".done_cnt"}, done_cnt - d0, 1);
   endtask

   task automatic run_small(input logic [W2-1:0] d, input string tag);
      int r0, t0;
      bit ok;
      @(negedge clock);
      data2_i = d;
      r0 = rises2;
      start2 = 1'b1;
      @(negedge clock);
      t0 = cyc;
      start2 = 1'b0;
      data2_i = ~d;
      wait_done2(LAT2 + 20, ok);
      check_int({tag, ".done_seen"}, int'(ok), 1);
      check_int({tag, ".latency"}, cyc - t0, LAT2);
      check({tag, ".data_o"}, W'(data2_o), W'(d));
      check({tag, ".mosi_word"}, W'(mosi2_word), W'(d));
      check_int({tag, ".rises"}, rises2 - r0, W2);
   endtask

   typedef struct {
      logic [W-1:0] d;
      logic [W-1:0] sw;
      bit           lb;
      logic [W-1:0] exp_o;
   } vec_t;

   vec_t vt[6];

   initial begin
      logic [W-1:0] w1, w2, wa, wb;
      int           t0, t1, d0, r0;
      bit           ok;

      vt[0].d  = 96'h0123_4567_89AB_CDEF_FEDC_BA98;
      vt[0].sw = '0;
      vt[0].lb = 1'b1;
      vt[1].d  = {12{8'h5A}};
      vt[1].sw = {12{8'hA5}};
      vt[1].lb = 1'b0;
      for (int i = 2; i < 6; i++) begin
         vt[i].d  = {$urandom(), $urandom(), $urandom()};
         vt[i].sw = {$urandom(), $urandom(), $urandom()};
         vt[i].lb = (i % 2) == 0;
      end
      for (int i = 0; i < 6; i++) vt[i].exp_o = vt[i].lb ? vt[i].d : vt[i].sw;

      // Reset state.
      repeat (3) @(negedge clock);
      check("rst.n_cs", W'(n_cs), W'(1));
      check("rst.sclk_mosi", W'({sclk, mosi}), W'(0));
      check("rst.busy_done", W'({busy, done}), W'(0));
      check("rst.data_o", data_o, '0);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      check("idle.n_cs", W'(n_cs), W'(1));

      for (int i = 0; i < 6; i++) run_txn(vt[i].d, vt[i].sw, vt[i].lb, vt[i].exp_o, $sformatf("vec%0d", i));

      // Back-to-back with start held high.
      w1 = {$urandom(), $urandom(), $urandom()};
      w2 = {$urandom(), $urandom(), $urandom()};
      @(negedge clock);
      loopback = 1'b1; data_i = w1; start = 1'b1;
      @(negedge clock);
      t0 = cyc;
      data_i = w2;
      wait_done(LAT + 50, ok);
      start = 1'b0;
      t1 = cyc;
      check_int("b2b.lat1", t1 - t0, LAT);
      check("b2b.word1", data_o, w1);
      @(negedge clock);
      wait_done(LAT + 50, ok);
      check_int("b2b.lat2", cyc - t1, LAT);
      check("b2b.word2", data_o, w2);
      check_int("b2b.ncs_gap", last_hi_run, 1);
      repeat (5) @(negedge clock);

      // Start while busy is ignored.
      wa = {$urandom(), $urandom(), $urandom()};
      wb = ~wa;
      @(negedge clock);
      d0 = done_cnt;
      data_i = wa; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (200) @(negedge clock);
      data_i = wb; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      wait_done(LAT + 50, ok);
      check("busy_start.data_o", data_o, wa);
      check("busy_start.mosi", mosi_word, wa);
      repeat (20) @(negedge clock);
      check_int("busy_start.dones", done_cnt - d0, 1);
      check("busy_start.idle", W'(busy), W'(0));

      // Async reset in the middle of bit 40.
      @(negedge clock);
      d0 = done_cnt; r0 = rises;
      data_i = wa; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (rises - r0 >= 40) break;
         @(negedge clock);
      end
      check_int("arst.reach_bit40", rises - r0, 40);
      #2 reset = 1'b1;
      #1;
      check("arst.pins", W'({n_cs, sclk, busy, mosi}), W'(4'b1000));
      @(negedge clock);
      reset = 1'b0;
      repeat (LAT + 20) @(negedge clock);
      check_int("arst.no_done", done_cnt - d0, 0);
      run_txn(wb, '0, 1'b1, wb, "after_rst");

      // Small instance: WIDTH=8, CLK_DIV=3, CS_SETUP=1, CS_HOLD=1.
      run_small(8'hC3, "small_c3");
      for (int i = 0; i < 3; i++) run_small(W2'($urandom_range(0, 255)), $sformatf("small_rnd%0d", i));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI master (mode 0, MSB first) that generates n_cs, sclk and mosi, and captures miso, one fixed-width word per transaction.
- Counterpart of the existing 96-bit spi_slave; used by the host-side bridge and by board-level test harnesses that drive slave-side datapath cores.
- Fully synchronous to `clock`: sclk is a registered, divided output and is never used as a clock.

Parameters:
- WIDTH, 96: bits per transaction; data_i/data_o width.
- CLK_DIV, 4: sclk half-period in `clock` cycles. Legal: ≥ 3 (spi_slave needs ≥ 3 low-phase cycles to update miso).
- CS_SETUP, 2: `clock` cycles from n_cs falling to first sclk rising phase start. Legal: ≥ 1.
- CS_HOLD, 2: `clock` cycles from last sclk falling to n_cs rising. Legal: ≥ 1.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request a transaction; sampled only in IDLE
- data_i  in  WIDTH  word to transmit; latched on start acceptance
- busy  out  1  high from the cycle after start acceptance until the done cycle, exclusive
- done  out  1  single-cycle pulse; data_o valid
- data_o  out  WIDTH  last received word; held until next done
- n_cs  out  1  chip select, active low
- sclk  out  1  serial clock, idle low
- mosi  out  1  serial data out
- miso  in  1  serial data in

Behaviour:
- Reset (async assert, release synchronous to clock):
  - state=IDLE; n_cs=1, sclk=0, mosi=0, busy=0, done=0, data_o=0.
  - Shift registers and counters cleared.
  - Reset mid-transaction aborts immediately; no done pulse.
- All outputs are registered.
- States: IDLE, SETUP, LOW, HIGH, HOLD. Counters: phase counter (log2 of max(CLK_DIV, CS_SETUP, CS_HOLD)) and bit counter (clog2(WIDTH+1)).
- IDLE:
  - n_cs=1, sclk=0, mosi=0.
  - start=1: tx <= data_i, rx <= 0, bit counter=0, go SETUP. start is accepted in the done cycle too, which guarantees n_cs high for ≥ 1 cycle between words.
- SETUP:
  - n_cs=0, mosi=tx[WIDTH-1], sclk=0.
  - After CS_SETUP cycles, go LOW.
- LOW:
  - sclk=0 for CLK_DIV cycles; mosi stable.
  - On the last LOW cycle: rx <= {rx[WIDTH-2:0], miso}; go HIGH.
- HIGH:
  - sclk=1 for CLK_DIV cycles.
  - On the last HIGH cycle, bit counter +1.
    - If the count reaches WIDTH: go HOLD.
    - Else: tx shifts left, mosi <= next bit (changes with sclk falling), go LOW.
- HOLD:
  - sclk=0, n_cs=0 for CS_HOLD cycles.
  - Then go IDLE: n_cs=1, done=1 for one cycle, data_o <= rx.
- Latency: done asserts exactly 1 + CS_SETUP + 2·CLK_DIV·WIDTH + CS_HOLD cycles after the start-acceptance edge.
- Exactly WIDTH sclk rising edges per transaction; no runt pulses.
- Boundary conditions:
  - start while busy: ignored (not queued).
  - data_i changes after acceptance: no effect.
  - miso is sampled at the end of the low phase, before sclk rises. A slave updating miso within CLK_DIV−1 cycles after sclk falls is captured correctly.

Decomposition:
- Shared package spi_defs: state encoding constants (IDLE..HOLD), default SPI_WORD_WIDTH=96, default SPI_CLK_DIV=4.
- No sub-module; the phase timer is a single inline counter reloaded per state.

Test Plan:
- Loopback (mosi→miso) with defaults: start, data_i=96'h0123_4567_89AB_CDEF_FEDC_BA98 → done after 1+2+768+2=773 cycles; data_o equals data_i; exactly 96 sclk rises.
- Against spi_slave (CLK_DIV=4):
  - Slave data_i=96'hA5A5…A5; master sends 96'h5A5A…5A.
  - Slave data_o=…5A; master data_o=…A5.
  - Both done pulses occur, slave's before master's.
- Back-to-back: start held high continuously → second transaction accepted in the done cycle; n_cs high for exactly 1 cycle between words; both words correct.
- Start while busy: pulse start mid-transaction with different data_i → ignored; exactly one done; transmitted word is the originally latched one.
- Async reset at bit 40 → same cycle n_cs=1, sclk=0, busy=0; no done; next start completes normally with correct data.
- Parameter sweep WIDTH=8, CLK_DIV=3, CS_SETUP=1, CS_HOLD=1: send 8'hC3 in loopback → data_o=8'hC3, done at cycle 1+1+48+1=51.
